// File: rtl/pair_scheduler_if.sv
// Pair issue / response channel between the scheduler and the
// distance/insert pipeline.
interface pair_scheduler_if #(
    parameter int IDX_W = 10
);
    logic             pair_valid;
    logic             pair_ready;
    logic [IDX_W-1:0] pair_i;
    logic [IDX_W-1:0] pair_j;
    logic             pair_last;
    logic             rsp_valid;

    modport master (
        output pair_valid,
        output pair_i,
        output pair_j,
        output pair_last,
        input  pair_ready,
        input  rsp_valid
    );

    modport slave (
        input  pair_valid,
        input  pair_i,
        input  pair_j,
        input  pair_last,
        output pair_ready,
        output rsp_valid
    );
endinterface

// File: rtl/pair_scheduler.sv
// Enumerates all pairs i<j over N elements, issues them downstream
// under a credit limit and reports completion once all are answered.
module pair_scheduler #(
    parameter int MAX_ELEM        = 1000,
    parameter int IDX_W           = 10,
    parameter int CNT_W           = 20,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IDX_W:0]     num_elem,
    input  logic               abort,
    pair_scheduler_if.master   bus,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               err,
    output logic [CNT_W-1:0]   pair_count
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] idx_i;
    logic [IDX_W-1:0] idx_j;
    logic [IDX_W:0]   n_reg;
    logic [IDX_W:0]   n_eff;
    logic [OUT_W-1:0] outstanding;
    logic             credit_ok;
    logic             at_last_j;
    logic             last_pair;
    logic             offer;
    logic             xfer;
    logic             accept_start;

    // Element count is clamped to the largest supported table.
    assign n_eff = (num_elem > (IDX_W+1)'(MAX_ELEM))
                 ? (IDX_W+1)'(MAX_ELEM) : num_elem;

    // Credits come only from the registered counter, never bypassed.
    assign credit_ok = outstanding < OUT_W'(MAX_OUTSTANDING);
    assign at_last_j = {1'b0, idx_j} == n_reg - 1'b1;
    assign last_pair = at_last_j
                    && ({1'b0, idx_i} == n_reg - 2'd2);
    assign xfer      = offer && bus.pair_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nx       = state;
        offer          = 1'b0;
        accept_start   = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        bus.pair_valid = 1'b0;
        bus.pair_last  = 1'b0;
        bus.pair_i     = idx_i;
        bus.pair_j     = idx_j;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_nx = (n_eff >= (IDX_W+1)'(2)) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                busy = 1'b1;
                if (abort) begin
                    state_nx = DRAIN;
                end else begin
                    offer = credit_ok;
                    if (offer && bus.pair_ready && last_pair) begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (outstanding == '0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        bus.pair_valid = offer;
        bus.pair_last  = offer && last_pair;
    end

    // Pair indices, run count and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_i      <= '0;
            idx_j      <= '0;
            n_reg      <= '0;
            pair_count <= '0;
            aborted    <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (bus.rsp_valid && outstanding == '0) begin
                err <= 1'b1;
            end
            if (state == ISSUE && abort) begin
                aborted <= 1'b1;
            end
            if (accept_start) begin
                n_reg      <= n_eff;
                idx_i      <= '0;
                idx_j      <= IDX_W'(1);
                pair_count <= '0;
                aborted    <= 1'b0;
                err        <= 1'b0;
            end else if (xfer) begin
                pair_count <= pair_count + 1'b1;
                if (at_last_j) begin
                    idx_i <= idx_i + 1'b1;
                    idx_j <= idx_i + IDX_W'(2);
                end else begin
                    idx_j <= idx_j + 1'b1;
                end
            end
        end
    end

    // Outstanding credit counter; a spurious response never underflows it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({xfer, bus.rsp_valid})
                2'b10: outstanding <= outstanding + 1'b1;
                2'b01: begin
                    if (outstanding != '0) begin
                        outstanding <= outstanding - 1'b1;
                    end
                end
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_pair_scheduler.sv
// Directed bench for pair_scheduler: enumeration, credits,
// backpressure, degenerate N, abort, error flag and reset.
module tb_pair_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [10:0] num_elem = '0;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        err;
    logic [19:0] pair_count;

    pair_scheduler_if #(.IDX_W(10)) bus ();

    always #5 clk = ~clk;

    pair_scheduler #(
        .MAX_ELEM(1000),
        .IDX_W(10),
        .CNT_W(20),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .num_elem(num_elem),
        .abort(abort),
        .bus(bus),
        .busy(busy),
        .done(done),
        .aborted(aborted),
        .err(err),
        .pair_count(pair_count)
    );

    int errors = 0;
    int checks = 0;
    int qi[$];
    int qj[$];
    int ql[$];
    int done_cnt;
    int stab_viol;
    bit busy_seen;
    bit valid_seen;
    bit last_valid;
    bit last_done;
    bit last_xfer;
    bit prev_hold;
    int prev_i;
    int prev_j;
    int prev_l;

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        qi.delete();
        qj.delete();
        ql.delete();
        done_cnt   = 0;
        stab_viol  = 0;
        busy_seen  = 0;
        valid_seen = 0;
        prev_hold  = 0;
    endtask

    // One clock cycle: drive at negedge, sample 1ns later.
    task automatic cyc(input bit rdy, input bit rsp, input bit ab);
        @(negedge clk);
        start          = 1'b0;
        bus.pair_ready = rdy;
        bus.rsp_valid  = rsp;
        abort          = ab;
        #1;
        last_valid = bus.pair_valid;
        last_done  = done;
        last_xfer  = bus.pair_valid && rdy;
        if (bus.pair_valid) valid_seen = 1;
        if (busy) busy_seen = 1;
        if (done) done_cnt++;
        if (prev_hold && (!bus.pair_valid || int'(bus.pair_i) != prev_i
            || int'(bus.pair_j) != prev_j || int'(bus.pair_last) != prev_l))
            stab_viol++;
        prev_hold = bus.pair_valid && !rdy;
        prev_i    = int'(bus.pair_i);
        prev_j    = int'(bus.pair_j);
        prev_l    = int'(bus.pair_last);
        if (last_xfer) begin
            qi.push_back(int'(bus.pair_i));
            qj.push_back(int'(bus.pair_j));
            ql.push_back(int'(bus.pair_last));
        end
    endtask

    task automatic kick(input int n);
        @(negedge clk);
        start          = 1'b1;
        num_elem       = 11'(n);
        bus.pair_ready = 1'b0;
        bus.rsp_valid  = 1'b0;
        abort          = 1'b0;
        clear_log();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_valid", bus.pair_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_count", pair_count, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin : main
        int ei[6];
        int ej[6];
        int k;
        bit rn;
        logic [31:0] pat;
        ei = '{0, 0, 0, 1, 1, 2};
        ej = '{1, 2, 3, 2, 3, 3};
        pat = 32'b1011_0010_0110_1100_1001_0111_0001_1010;
        bus.pair_ready = 1'b0;
        bus.rsp_valid  = 1'b0;
        clear_log();

        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        check("reset_valid", bus.pair_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_aborted", aborted, 0);
        check("reset_count", pair_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // Full enumeration, N=4.
        kick(4);
        rn = 0;
        repeat (12) begin
            cyc(1, rn, 0);
            rn = last_xfer;
        end
        check("enum_xfers", qi.size(), 6);
        for (int m = 0; m < 6; m++) begin
            check("enum_i", m < qi.size() ? qi[m] : -1, ei[m]);
            check("enum_j", m < qj.size() ? qj[m] : -1, ej[m]);
            check("enum_last", m < ql.size() ? ql[m] : -1, m == 5 ? 1 : 0);
        end
        check("enum_count", pair_count, 6);
        check("enum_done", done_cnt, 1);
        check("enum_aborted", aborted, 0);
        check("enum_err", err, 0);

        // Credit limit, N=10, no responses.
        kick(10);
        repeat (20) cyc(1, 0, 0);
        check("credit_xfers", qi.size(), 4);
        check("credit_valid", last_valid, 0);
        check("credit_busy", busy, 1);
        cyc(1, 1, 0);
        repeat (3) cyc(1, 0, 0);
        check("credit_one_more", qi.size(), 5);
        check("credit_count", pair_count, 5);
        pulse_reset();

        // Backpressure, N=5.
        kick(5);
        rn = 0;
        for (int c = 0; c < 60; c++) begin
            cyc(pat[c % 32], rn, 0);
            rn = last_xfer;
        end
        check("bp_xfers", qi.size(), 10);
        k = 0;
        for (int a = 0; a < 4; a++) begin
            for (int b = a + 1; b < 5; b++) begin
                check("bp_i", k < qi.size() ? qi[k] : -1, a);
                check("bp_j", k < qj.size() ? qj[k] : -1, b);
                k++;
            end
        end
        check("bp_stable", stab_viol, 0);
        check("bp_count", pair_count, 10);
        check("bp_done", done_cnt, 1);

        // Degenerate N=1 and N=0.
        for (int n = 1; n >= 0; n--) begin
            kick(n);
            cyc(0, 0, 0);
            check("degen_done_t1", last_done, 1);
            check("degen_count", pair_count, 0);
            repeat (3) cyc(1, 0, 0);
            check("degen_done_cnt", done_cnt, 1);
            check("degen_busy", busy_seen, 0);
            check("degen_valid", valid_seen, 0);
        end

        // Abort after 7 transfers with 3 outstanding, N=100.
        kick(100);
        repeat (4) cyc(1, 0, 0);
        repeat (4) cyc(1, 1, 0);
        check("abort_pre_xfers", qi.size(), 7);
        cyc(1, 0, 1);
        check("abort_valid", last_valid, 0);
        repeat (2) cyc(1, 0, 0);
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        check("abort_early_done", done_cnt, 0);
        repeat (3) cyc(1, 0, 0);
        check("abort_done", done_cnt, 1);
        check("abort_xfers", qi.size(), 7);
        check("abort_flag", aborted, 1);
        check("abort_count", pair_count, 7);
        check("abort_err", err, 0);

        // Spurious response in IDLE, start clears, reset mid-ISSUE.
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        check("err_set", err, 1);
        kick(10);
        cyc(1, 0, 0);
        check("err_clear", err, 0);
        check("start_clears_aborted", aborted, 0);
        repeat (2) cyc(1, 0, 0);
        check("pre_rst_valid", bus.pair_valid, 1);
        check("pre_rst_count", pair_count, 2);
        rst = 1'b1;
        #1;
        check("async_valid", bus.pair_valid, 0);
        check("async_busy", busy, 0);
        check("async_count", pair_count, 0);
        check("async_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) cyc(1, 0, 0);
        check("rst_no_done", done_cnt, 0);
        check("rst_no_xfer", qi.size(), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
